// File: rtl/data_mem_responder.sv
// Fixed-latency word-addressed memory responder: one READ/WRITE in flight, DONE pulse on completion.
// Optional `DMEM_BOUNDS_CHECK_EN flags requests whose address exceeds the implemented depth.
module data_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 26,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  READ,
    input  logic                  WRITE,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [3:0]              cnt, cnt_n;
    logic                    accept, commit;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    rd_q, wr_q;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic                    err_q;
    logic                    illegal, oob;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [DATA_WIDTH-1:0]   mem [0:(1<<DEPTH_LOG2)-1];

    assign idx     = addr_q[DEPTH_LOG2-1:0];
    assign illegal = rd_q & wr_q;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign oob = |addr_q[ADDR_WIDTH-1:DEPTH_LOG2];
`else
    // Upper address bits alias onto the implemented array.
    logic addr_hi_unused;
    assign addr_hi_unused = |addr_q[ADDR_WIDTH-1:DEPTH_LOG2];
    assign oob = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state)
            S_IDLE, S_RESP: begin
                if (READ | WRITE) begin
                    accept  = 1'b1;
                    state_n = S_WAIT;
                    cnt_n   = 4'(LATENCY - 1);
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    commit  = 1'b1;
                    state_n = S_RESP;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            err_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            err_q <= commit & (illegal | oob);
            if (commit && rd_q && !wr_q)
                data_out_q <= oob ? '0 : mem[idx];
        end
    end

    // Request holding registers carry data only, so they need no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            addr_q <= ADDR;
            data_q <= DATA_IN;
            rd_q   <= READ;
            wr_q   <= WRITE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && commit && wr_q && !rd_q && !oob)
            mem[idx] <= data_q;
    end

    assign BUSY     = (state == S_WAIT);
    assign DONE     = (state == S_RESP);
    assign ERR      = err_q;
    assign DATA_OUT = data_out_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder with a word-array reference model.
// Honours `DMEM_BOUNDS_CHECK_EN when computing expected results.
module tb_data_mem_responder;

    localparam int LAT = 2;
`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [25:0] ADDR = '0;
    logic [31:0] DATA_IN = '0;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [31:0] DATA_OUT;
    logic        BUSY, DONE, ERR;

    int checks = 0;
    int failures = 0;

    logic [31:0] mdl [0:1023];
    logic [31:0] exp_dout = 32'h0;

    data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(26), .DEPTH_LOG2(10), .LATENCY(LAT)) dut (
        .CLK(CLK), .RST(RST), .ADDR(ADDR), .DATA_IN(DATA_IN), .READ(READ), .WRITE(WRITE),
        .DATA_OUT(DATA_OUT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Issue one request from an idle responder and observe its completion.
    task automatic run_req(input logic rd, input logic wr, input logic [25:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] dout, output logic e, output int busy_bad);
        @(negedge CLK);
        READ = rd; WRITE = wr; ADDR = a; DATA_IN = d;
        @(posedge CLK);
        @(negedge CLK);
        READ = 1'b0; WRITE = 1'b0;
        lat = -1; busy_bad = 0; dout = 'x; e = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            if (DONE) begin
                lat = i - 1; dout = DATA_OUT; e = ERR;
                if (BUSY) busy_bad++;
                break;
            end
            if (!BUSY) busy_bad++;
            @(negedge CLK);
        end
    endtask

    task automatic model_req(input logic rd, input logic wr, input logic [25:0] a, input logic [31:0] d,
                             output logic exp_err);
        logic bad;
        bad = BOUNDS && (a[25:10] != 16'd0);
        exp_err = (rd & wr) | bad;
        if (!(rd & wr)) begin
            if (wr && !bad) mdl[a[9:0]] = d;
            if (rd) exp_dout = bad ? 32'h0 : mdl[a[9:0]];
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({DATA_OUT, BUSY, DONE, ERR} !== 35'h0) begin
            failures++;
            $display("FAIL reset_values: got dout=%h busy=%b done=%b err=%b, want all zero", DATA_OUT, BUSY, DONE, ERR);
        end
        @(negedge CLK);
        RST = 1'b0;
        exp_dout = 32'h0;
    endtask

    task automatic test_write_read();
        int lat, bb; logic [31:0] dout; logic e, ee;
        run_req(1'b0, 1'b1, 26'h005, 32'hDEADBEEF, lat, dout, e, bb);
        model_req(1'b0, 1'b1, 26'h005, 32'hDEADBEEF, ee);
        checks++;
        if (lat !== LAT || bb !== 0 || e !== ee) begin
            failures++;
            $display("FAIL write_resp: got lat=%0d busy_bad=%0d err=%b, want lat=%0d busy_bad=0 err=%b", lat, bb, e, LAT, ee);
        end
        run_req(1'b1, 1'b0, 26'h005, 32'h0, lat, dout, e, bb);
        model_req(1'b1, 1'b0, 26'h005, 32'h0, ee);
        checks++;
        if (lat !== LAT || dout !== exp_dout || e !== ee) begin
            failures++;
            $display("FAIL read_back: got lat=%0d dout=%h err=%b, want lat=%0d dout=%h err=%b", lat, dout, e, LAT, exp_dout, ee);
        end
    endtask

    task automatic test_back_to_back();
        int first, gap, ndone; logic [31:0] dout; logic ee;
        @(negedge CLK);
        WRITE = 1'b1; READ = 1'b0; ADDR = 26'h010; DATA_IN = 32'h12345678;
        @(posedge CLK);
        @(negedge CLK);
        WRITE = 1'b0; READ = 1'b1;
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            if (DONE) begin first = i - 1; break; end
            @(negedge CLK);
        end
        model_req(1'b0, 1'b1, 26'h010, 32'h12345678, ee);
        checks++;
        if (first !== LAT) begin
            failures++;
            $display("FAIL b2b_first_done: got lat=%0d, want %0d", first, LAT);
        end
        gap = -1; dout = 'x;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (i == 1) READ = 1'b0;
            if (DONE) begin gap = i; dout = DATA_OUT; break; end
        end
        READ = 1'b0;
        model_req(1'b1, 1'b0, 26'h010, 32'h0, ee);
        checks++;
        if (gap !== LAT + 1 || dout !== exp_dout) begin
            failures++;
            $display("FAIL b2b_read: got gap=%0d dout=%h, want gap=%0d dout=%h", gap, dout, LAT + 1, exp_dout);
        end
        // A read pulsed only while busy must be dropped.
        @(negedge CLK);
        READ = 1'b1; ADDR = 26'h010;
        @(posedge CLK);
        @(negedge CLK);
        READ = 1'b0;
        @(negedge CLK);
        READ = 1'b1; ADDR = 26'h005;
        @(negedge CLK);
        READ = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (DONE) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++;
            $display("FAIL busy_drop: got %0d extra DONE pulses, want 0", ndone);
        end
    endtask

    task automatic test_illegal();
        int lat, bb; logic [31:0] dout; logic e, ee;
        run_req(1'b1, 1'b1, 26'h005, 32'h0, lat, dout, e, bb);
        model_req(1'b1, 1'b1, 26'h005, 32'h0, ee);
        checks++;
        if (lat !== LAT || e !== ee || dout !== exp_dout) begin
            failures++;
            $display("FAIL illegal_op: got lat=%0d err=%b dout=%h, want lat=%0d err=%b dout=%h", lat, e, dout, LAT, ee, exp_dout);
        end
        run_req(1'b1, 1'b0, 26'h005, 32'h0, lat, dout, e, bb);
        model_req(1'b1, 1'b0, 26'h005, 32'h0, ee);
        checks++;
        if (dout !== exp_dout || e !== ee) begin
            failures++;
            $display("FAIL illegal_keep: got dout=%h err=%b, want dout=%h err=%b", dout, e, exp_dout, ee);
        end
    endtask

    task automatic test_bounds();
        int lat, bb; logic [31:0] dout; logic e, ee;
        run_req(1'b0, 1'b1, 26'h000, 32'h11110000, lat, dout, e, bb);
        model_req(1'b0, 1'b1, 26'h000, 32'h11110000, ee);
        run_req(1'b0, 1'b1, 26'h400, 32'hCAFEF00D, lat, dout, e, bb);
        model_req(1'b0, 1'b1, 26'h400, 32'hCAFEF00D, ee);
        checks++;
        if (e !== ee || lat !== LAT) begin
            failures++;
            $display("FAIL bounds_write: got err=%b lat=%0d, want err=%b lat=%0d", e, lat, ee, LAT);
        end
        run_req(1'b1, 1'b0, 26'h000, 32'h0, lat, dout, e, bb);
        model_req(1'b1, 1'b0, 26'h000, 32'h0, ee);
        checks++;
        if (dout !== exp_dout || e !== ee) begin
            failures++;
            $display("FAIL bounds_read0: got dout=%h err=%b, want dout=%h err=%b", dout, e, exp_dout, ee);
        end
        run_req(1'b1, 1'b0, 26'h400, 32'h0, lat, dout, e, bb);
        model_req(1'b1, 1'b0, 26'h400, 32'h0, ee);
        checks++;
        if (dout !== exp_dout || e !== ee) begin
            failures++;
            $display("FAIL bounds_read_hi: got dout=%h err=%b, want dout=%h err=%b", dout, e, exp_dout, ee);
        end
    endtask

    task automatic test_reset_midop();
        int lat, bb, ndone; logic [31:0] dout; logic e, ee;
        run_req(1'b0, 1'b1, 26'h007, 32'h00000001, lat, dout, e, bb);
        model_req(1'b0, 1'b1, 26'h007, 32'h00000001, ee);
        run_req(1'b1, 1'b0, 26'h007, 32'h0, lat, dout, e, bb);
        model_req(1'b1, 1'b0, 26'h007, 32'h0, ee);
        @(negedge CLK);
        WRITE = 1'b1; ADDR = 26'h007; DATA_IN = 32'hFFFFFFFF;
        @(posedge CLK);
        @(negedge CLK);
        WRITE = 1'b0;
        checks++;
        if (BUSY !== 1'b1) begin
            failures++;
            $display("FAIL midop_busy: got busy=%b, want 1", BUSY);
        end
        #2 RST = 1'b1;
        #1;
        exp_dout = 32'h0;
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0 || DATA_OUT !== exp_dout) begin
            failures++;
            $display("FAIL async_reset: got busy=%b done=%b err=%b dout=%h, want 0 0 0 %h", BUSY, DONE, ERR, DATA_OUT, exp_dout);
        end
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (DONE) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++;
            $display("FAIL midop_no_done: got %0d DONE pulses, want 0", ndone);
        end
        run_req(1'b1, 1'b0, 26'h007, 32'h0, lat, dout, e, bb);
        model_req(1'b1, 1'b0, 26'h007, 32'h0, ee);
        checks++;
        if (dout !== exp_dout || dout !== 32'h00000001) begin
            failures++;
            $display("FAIL midop_abort: got dout=%h, want %h", dout, exp_dout);
        end
    endtask

    task automatic test_random();
        int lat, bb, r; logic [31:0] dout, d; logic e, ee, rd, wr; logic [25:0] a;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            run_req(1'b0, 1'b1, 26'(i), d, lat, dout, e, bb);
            model_req(1'b0, 1'b1, 26'(i), d, ee);
        end
        for (int n = 0; n < 40; n++) begin
            r  = int'($urandom_range(0, 5));
            rd = (r <= 2) || (r == 5);
            wr = (r >= 3);
            a  = {($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'd0, 6'd0, 4'($urandom_range(0, 15))};
            d  = $urandom;
            run_req(rd, wr, a, d, lat, dout, e, bb);
            model_req(rd, wr, a, d, ee);
            checks++;
            if (lat !== LAT || bb !== 0 || e !== ee || dout !== exp_dout) begin
                failures++;
                $display("FAIL random_%0d: rd=%b wr=%b a=%h got lat=%0d bb=%0d err=%b dout=%h, want lat=%0d bb=0 err=%b dout=%h",
                         n, rd, wr, a, lat, bb, e, dout, LAT, ee, exp_dout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_illegal();
        test_bounds();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

- Memory-side responder for the processor's data/instruction memory port.
- Accepts one READ or WRITE request at a time on the ADDR / DATA_IN / READ / WRITE interface that the datapath drives.
- Holds the request for a fixed, parameterised number of wait cycles, then commits the write or returns read data with a one-cycle DONE pulse.
- Backed by a word-addressed synchronous storage array, and used as the memory model behind the datapath in system simulation.

## Interface

Parameters:
- DATA_WIDTH, 32: word width in bits.
- ADDR_WIDTH, 26: request address width (word address).
- DEPTH_LOG2, 10: log2 of implemented words (1024).
- LATENCY, 2: cycles from request capture to DONE; legal range 1..15.

Ports:
- CLK  input  1  single clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- ADDR  input  ADDR_WIDTH  word address of the request.
- DATA_IN  input  DATA_WIDTH  write data, sampled with the request.
- READ  input  1  read request.
- WRITE  input  1  write request.
- DATA_OUT  output  DATA_WIDTH  read data, valid from DONE and held until the next read completes.
- BUSY  output  1  request in flight; new requests ignored.
- DONE  output  1  one-cycle completion pulse.
- ERR  output  1  completion had an error; valid only while DONE=1.

## Operation

- **States:** IDLE, WAIT, RESP (2-bit encoded). A 4-bit wait counter and latched address, data and opcode registers back them.
- **Acceptance:** a request is accepted at a rising edge where the state is IDLE or RESP and (READ | WRITE)=1.
  - Capture ADDR, DATA_IN and the opcode.
  - Load the counter with LATENCY-1 and go to WAIT.
- **WAIT:**
  - BUSY=1.
  - The counter decrements each edge.
  - At an edge where counter==0, go to RESP.
- **RESP edge** (the edge entering RESP):
  - For a write, the array word at the latched address gets the latched data.
  - For a read, DATA_OUT gets the array word at the latched address.
  - A read issued after a completed write to the same address returns the new data.
- **RESP** lasts one cycle: DONE=1, BUSY=0.
  - A new request at the edge ending RESP is accepted (back-to-back).
  - Otherwise go to IDLE.
- **Requests while BUSY=1** are dropped, not queued. The requester must hold READ/WRITE until it sees BUSY=0.
- **READ and WRITE both high at capture:**
  - Accepted and run through normal latency.
  - The array is unchanged and DATA_OUT is unchanged.
  - ERR=1 during RESP.
- **Array indexing** uses ADDR[DEPTH_LOG2-1:0]. The upper address bits are handled per the Configuration section.
- **DATA_OUT** changes only at a successful read completion.
- **Reset:**
  - DATA_OUT=0, BUSY=0, DONE=0, ERR=0, state=IDLE, counter=0.
  - The array is not cleared.
  - A reset during WAIT aborts the request: no write is committed.

## Timing

- Request sampled at edge k; DONE high in the cycle after edge k+LATENCY. BUSY is high for cycles k..k+LATENCY-1.
- With LATENCY=1: capture at k, RESP entered at k+1.
- Maximum throughput is one request per LATENCY+1 cycles (capture at the RESP-ending edge).
- All outputs are registered; there is no combinational path from inputs to outputs.
- RST asserts asynchronously: outputs take reset values immediately. Release takes effect at the next rising edge.

## Configuration

- Macro `DMEM_BOUNDS_CHECK_EN`.
- **Defined:** a request with any nonzero ADDR[ADDR_WIDTH-1:DEPTH_LOG2] completes with ERR=1.
  - A write is dropped.
  - A read leaves DATA_OUT=0.
- **Undefined:** the upper bits are ignored and addresses alias modulo 2^DEPTH_LOG2. ERR is raised only for simultaneous READ&WRITE.

## Test plan

All scenarios use the defaults (LATENCY=2, DEPTH_LOG2=10).

- **Reset values:** RST=1 at any time → DATA_OUT=0x00000000, BUSY=0, DONE=0, ERR=0 without waiting for a clock edge.
- **Write then read:**
  - WRITE addr 0x005 data 0xDEADBEEF at edge k → BUSY during k..k+1, DONE at k+2, ERR=0.
  - Then READ 0x005 → DONE two edges after capture, DATA_OUT=0xDEADBEEF.
- **Back-to-back:**
  - Write 0x12345678 to 0x010, with READ 0x010 held asserted → READ is captured at the RESP-ending edge.
  - Next DONE comes three edges after the first DONE with DATA_OUT=0x12345678.
  - READ pulsed during BUSY alone → no response.
- **Illegal opcode:** READ=WRITE=1 at addr 0x005 with DATA_IN=0x0 → DONE with ERR=1, DATA_OUT unchanged, later read of 0x005 still 0xDEADBEEF.
- **Bounds:** WRITE 0xCAFEF00D to 0x400, then READ 0x000.
  - With `DMEM_BOUNDS_CHECK_EN`: ERR=1 on the write, and 0x000 keeps its prior value.
  - Without it: ERR=0 and the read of 0x000 returns 0xCAFEF00D.
- **Reset mid-op:**
  - 0x007 holds 0x00000001; start WRITE 0x007 data 0xFFFFFFFF.
  - Assert RST one cycle after capture → BUSY drops immediately, no DONE.
  - After release, READ 0x007 returns 0x00000001.
